chr_tile_fetcher: RTL and testbench

- Background pattern fetch stage. Sits directly downstream of the CHR pattern memory and consumes its read data.
- Accepts one tile request at a time: tile index, pattern table select, fine Y, flips.
- Issues the low-plane and high-plane pattern byte reads to CHR memory, buffers one fetched tile, and serialises it into 2-bit pixels at one pixel per enabled dot.

---
 rtl/chr_tile_fetcher.sv | 110 +++++++++++
 tb/tb_chr_tile_fetcher.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chr_tile_fetcher.sv
// Background pattern fetch: reads low/high CHR planes for one tile row, buffers them,
// and shifts out 2-bit pixels MSB first, one per enabled dot.
module chr_tile_fetcher #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tile_valid,
   output logic              tile_ready,
   input  logic [7:0]        tile_index,
   input  logic              table_sel,
   input  logic [2:0]        fine_y,
   input  logic              flip_h,
   input  logic              flip_v,
   output logic [ADDR_W-1:0] chr_addr,
   input  logic [7:0]        chr_data,
   input  logic              pix_en,
   output logic [1:0]        pixel,
   output logic              pix_valid,
   output logic              underrun
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       table_q;
   logic [7:0] tile_q;
   logic       flip_h_q;
   logic [2:0] row_q;
   logic [7:0] lo_buf;
   logic [7:0] hi_buf;
   logic       buf_full;
   logic [7:0] sh_lo;
   logic [7:0] sh_hi;
   logic [3:0] count;
   logic       accept;
   logic       load;

   function automatic logic [7:0] mirror(input logic [7:0] b, input logic en);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return en ? r : b;
   endfunction

   assign tile_ready = (state == IDLE) && !buf_full;
   assign accept     = tile_valid && tile_ready;
   // Reload on the same edge the last pixel leaves so tiles stream without a gap.
   assign load       = buf_full && ((count == 4'd0) || ((count == 4'd1) && pix_en));
   assign pix_valid  = (count != 4'd0);
   assign pixel      = pix_valid ? {sh_hi[7], sh_lo[7]} : 2'b00;

   always_comb begin
      state_nxt = state;
      chr_addr  = '0;
      case (state)
         IDLE: if (accept) state_nxt = LO;
         LO: begin
            chr_addr  = ADDR_W'({table_q, tile_q, 1'b0, row_q});
            state_nxt = HI;
         end
         HI: begin
            chr_addr  = ADDR_W'({table_q, tile_q, 1'b1, row_q});
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         table_q  <= 1'b0;
         tile_q   <= '0;
         flip_h_q <= 1'b0;
         row_q    <= '0;
         lo_buf   <= '0;
         hi_buf   <= '0;
         buf_full <= 1'b0;
         sh_lo    <= '0;
         sh_hi    <= '0;
         count    <= '0;
         underrun <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            table_q  <= table_sel;
            tile_q   <= tile_index;
            flip_h_q <= flip_h;
            row_q    <= flip_v ? (3'd7 - fine_y) : fine_y;
         end
         // Memory answers within the cycle the address is driven.
         if (state == LO) lo_buf <= mirror(chr_data, flip_h_q);
         if (state == HI) hi_buf <= mirror(chr_data, flip_h_q);
         if (load) begin
            sh_lo <= lo_buf;
            sh_hi <= hi_buf;
            count <= 4'd8;
         end else if (pix_en && (count != 4'd0)) begin
            sh_lo <= {sh_lo[6:0], 1'b0};
            sh_hi <= {sh_hi[6:0], 1'b0};
            count <= count - 4'd1;
         end
         if (load) buf_full <= 1'b0;
         else if (state == HI) buf_full <= 1'b1;
         if (pix_en && (count == 4'd0)) underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_chr_tile_fetcher.sv
// Bench for chr_tile_fetcher: CHR memory model, pixel-stream scoreboard and directed tests.
module tb_chr_tile_fetcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tile_valid = 1'b0;
   logic        tile_ready;
   logic [7:0]  tile_index = '0;
   logic        table_sel = 1'b0;
   logic [2:0]  fine_y = '0;
   logic        flip_h = 1'b0;
   logic        flip_v = 1'b0;
   logic [15:0] chr_addr;
   logic [7:0]  chr_data = '0;
   logic        pix_en = 1'b0;
   logic [1:0]  pixel;
   logic        pix_valid;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:8191];
   logic [1:0] q[$];
   logic [1:0] dummy;
   int         age = 0;
   int         m_lo = 0;
   int         m_hi = 0;
   bit         model_on = 1'b0;

   chr_tile_fetcher #(.ADDR_W(16)) dut (
      .clk(clk), .reset(reset), .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_index(tile_index), .table_sel(table_sel), .fine_y(fine_y),
      .flip_h(flip_h), .flip_v(flip_v), .chr_addr(chr_addr), .chr_data(chr_data),
      .pix_en(pix_en), .pixel(pixel), .pix_valid(pix_valid), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // CHR memory reads on the falling edge
   always @(negedge clk) chr_data <= mem[chr_addr[12:0]];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Model: each accepted tile yields its 8 pixels in order; addresses one and two cycles after accept
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         age = 0;
      end else begin
         if (pix_en && pix_valid && q.size() > 0) dummy = q.pop_front();
         if (age == 2) age = 0;
         else if (age == 1) age = 2;
         if (tile_valid && tile_ready) begin
            int row;
            logic [7:0] lo, hi;
            row  = flip_v ? 7 - int'(fine_y) : int'(fine_y);
            m_lo = int'(table_sel) * 4096 + int'(tile_index) * 16 + row;
            m_hi = m_lo + 8;
            lo   = mem[m_lo];
            hi   = mem[m_hi];
            for (int i = 0; i < 8; i++) begin
               int b;
               b = flip_h ? i : 7 - i;
               q.push_back({hi[b], lo[b]});
            end
            age = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         int exp_addr;
         exp_addr = (age == 1) ? m_lo : (age == 2) ? m_hi : 0;
         check("chr_addr_model", {16'h0, chr_addr}, exp_addr);
         if (pix_valid) begin
            if (q.size() == 0) check("pix_valid_without_tile", {31'h0, pix_valid}, 0);
            else check("pixel_model", {30'h0, pixel}, {30'h0, q[0]});
         end else begin
            check("pixel_idle", {30'h0, pixel}, 0);
         end
      end
   end

   task automatic run_tile(input logic t, input logic [7:0] ti, input logic [2:0] fy,
                           input logic fh, input logic fv, input logic [15:0] a_lo,
                           input logic [15:0] a_hi, input logic [15:0] pxs, input string nm);
      @(negedge clk);
      check({nm, "_ready"}, {31'h0, tile_ready}, 1);
      table_sel = t; tile_index = ti; fine_y = fy; flip_h = fh; flip_v = fv;
      tile_valid = 1'b1;
      @(posedge clk);
      #1 tile_valid = 1'b0;
      @(negedge clk);
      check({nm, "_addr_lo"}, {16'h0, chr_addr}, {16'h0, a_lo});
      @(negedge clk);
      check({nm, "_addr_hi"}, {16'h0, chr_addr}, {16'h0, a_hi});
      check({nm, "_pv_early1"}, {31'h0, pix_valid}, 0);
      @(negedge clk);
      check({nm, "_pv_early2"}, {31'h0, pix_valid}, 0);
      @(negedge clk);
      check({nm, "_pv_rise"}, {31'h0, pix_valid}, 1);
      pix_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         check({nm, "_pixel"}, {30'h0, pixel}, {30'h0, pxs[15-2*i -: 2]});
      end
      @(negedge clk);
      pix_en = 1'b0;
      check({nm, "_pv_end"}, {31'h0, pix_valid}, 0);
      check({nm, "_underrun"}, {31'h0, underrun}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      int cyc, k, acc0, acc1, pvcount;
      bit started, gap;
      logic [7:0] b2b_lo [4];
      logic [7:0] b2b_hi [4];
      b2b_lo = '{8'hC3, 8'h5A, 8'h0F, 8'hE1};
      b2b_hi = '{8'h3C, 8'h99, 8'hF0, 8'h17};

      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      mem[13'h0213] = 8'hF0; mem[13'h021B] = 8'hAA;
      mem[13'h0214] = 8'h3C; mem[13'h021C] = 8'h81;
      mem[13'h1FF7] = 8'h01; mem[13'h1FFF] = 8'h80;
      for (int j = 0; j < 4; j++) begin
         mem[13'h0300 + 16*j] = b2b_lo[j];
         mem[13'h0308 + 16*j] = b2b_hi[j];
      end

      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_on = 1'b1;
      check("rst_tile_ready", {31'h0, tile_ready}, 1);
      check("rst_pix_valid", {31'h0, pix_valid}, 0);
      check("rst_pixel", {30'h0, pixel}, 0);
      check("rst_chr_addr", {16'h0, chr_addr}, 0);
      check("rst_underrun", {31'h0, underrun}, 0);

      run_tile(1'b0, 8'h21, 3'd3, 1'b0, 1'b0, 16'h0213, 16'h021B, 16'hDD88, "basic");
      run_tile(1'b0, 8'h21, 3'd3, 1'b1, 1'b0, 16'h0213, 16'h021B, 16'h2277, "flip_h");
      run_tile(1'b0, 8'h21, 3'd3, 1'b0, 1'b1, 16'h0214, 16'h021C, 16'h8552, "flip_v");
      run_tile(1'b1, 8'hFF, 3'd7, 1'b0, 1'b0, 16'h1FF7, 16'h1FFF, 16'h8001, "corner");

      // Back-to-back: four tiles queued with tile_valid held, pixels drained continuously
      k = 0; cyc = 0; acc0 = -1; acc1 = -1; pvcount = 0; started = 0; gap = 0;
      table_sel = 1'b0; fine_y = 3'd0; flip_h = 1'b0; flip_v = 1'b0;
      while (cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (k < 4) begin
            tile_index = 8'h30 + 8'(k);
            tile_valid = 1'b1;
         end else begin
            tile_valid = 1'b0;
         end
         if (pix_valid) begin
            if (!started) check("b2b_first_pixel", {30'h0, pixel}, 1);
            started = 1;
            pix_en = 1'b1;
            pvcount++;
         end else begin
            if (started && pvcount < 32) gap = 1;
            pix_en = 1'b0;
         end
         if (k < 4 && tile_ready) begin
            if (k == 0) acc0 = cyc;
            if (k == 1) acc1 = cyc;
            k++;
         end
      end
      tile_valid = 1'b0;
      pix_en = 1'b0;
      check("b2b_pixel_count", pvcount, 32);
      check("b2b_no_gap", {31'h0, gap}, 0);
      check("b2b_accept_spacing", acc1 - acc0, 4);
      check("b2b_all_consumed", q.size(), 0);
      check("b2b_underrun", {31'h0, underrun}, 0);

      // Starvation
      @(negedge clk);
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      check("starve_underrun", {31'h0, underrun}, 1);
      check("starve_pix_valid", {31'h0, pix_valid}, 0);

      // Reset while the HI read is in flight
      @(negedge clk);
      table_sel = 1'b0; tile_index = 8'h21; fine_y = 3'd3; flip_h = 1'b0; flip_v = 1'b0;
      tile_valid = 1'b1;
      @(posedge clk);
      #1 tile_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rsthi_addr_hi", {16'h0, chr_addr}, 16'h021B);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rsthi_tile_ready", {31'h0, tile_ready}, 1);
      check("rsthi_underrun", {31'h0, underrun}, 0);
      check("rsthi_pix_valid", {31'h0, pix_valid}, 0);
      check("rsthi_chr_addr", {16'h0, chr_addr}, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rsthi_no_pixels", {31'h0, pix_valid}, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
